// File: rtl/music_pkg.sv
// Shared widths and constants for the music player blocks.
package music_pkg;

  localparam int NOTE_WIDTH       = 6;
  localparam int DUR_WIDTH        = 6;
  localparam int NUM_VOICES_DEF   = 3;
  localparam int AGE_WIDTH_DEF    = 3;

  localparam logic [DUR_WIDTH-1:0] REST_DURATION = '0;

endpackage

// File: rtl/voice_slot.sv
// One polyphony voice: busy flag, remaining-beat counter and saturating age.
// Load beats decrement; flush beats load. Expire is the combinational 1->0 beat.
module voice_slot
  import music_pkg::*;
#(
  parameter int AGE_WIDTH = AGE_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 load_i,
  input  logic [DUR_WIDTH-1:0] dur_i,
  input  logic                 age_inc_i,
  input  logic                 tick_i,
  output logic                 busy_o,
  output logic [AGE_WIDTH-1:0] age_o,
  output logic                 expire_o
);

  logic                 busy_q, busy_d;
  logic [DUR_WIDTH-1:0] rem_q, rem_d;
  logic [AGE_WIDTH-1:0] age_q, age_d;

  assign expire_o = busy_q && tick_i && (rem_q == DUR_WIDTH'(1));
  assign busy_o   = busy_q;
  assign age_o    = age_q;

  always_comb begin
    busy_d = busy_q;
    rem_d  = rem_q;
    age_d  = age_q;
    if (flush_i) begin
      busy_d = 1'b0;
      rem_d  = '0;
      age_d  = '0;
    end else if (load_i) begin
      busy_d = 1'b1;
      rem_d  = dur_i;
      age_d  = '0;
    end else if (busy_q) begin
      // age_inc_i is asserted for any load in the bank; our own load was handled above
      if (age_inc_i && (age_q != {AGE_WIDTH{1'b1}})) begin
        age_d = age_q + AGE_WIDTH'(1);
      end
      if (tick_i) begin
        rem_d = rem_q - DUR_WIDTH'(1);
        if (rem_q == DUR_WIDTH'(1)) begin
          busy_d = 1'b0;
          age_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      rem_q  <= '0;
      age_q  <= '0;
    end else begin
      busy_q <= busy_d;
      rem_q  <= rem_d;
      age_q  <= age_d;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony allocator: lowest free voice, else oldest (VOICE_STEAL_EN) or drop.
// All outputs registered, one cycle after new_note/beat; accepts one new_note per cycle.
module voice_allocator
  import music_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int AGE_WIDTH  = AGE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  play,
  input  logic                  new_note,
  input  logic [NOTE_WIDTH-1:0] note,
  input  logic [DUR_WIDTH-1:0]  duration,
  input  logic                  beat,
  output logic [NUM_VOICES-1:0] load_voice,
  output logic [NOTE_WIDTH-1:0] voice_note,
  output logic [DUR_WIDTH-1:0]  voice_duration,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic [NUM_VOICES-1:0] voice_done,
  output logic                  note_done,
  output logic                  overflow
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  logic [NUM_VOICES-1:0] busy_w, expire_w, load_vec;
  logic [AGE_WIDTH-1:0]  age_w [NUM_VOICES];
  logic                  tick, any_load, accept, rest_note, drop, ovf_set, last_expire;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx, old_idx, sel_idx;
  logic [AGE_WIDTH-1:0]  old_age;

  logic [NUM_VOICES-1:0] load_voice_q, load_voice_d;
  logic [NUM_VOICES-1:0] voice_done_q, voice_done_d;
  logic [NOTE_WIDTH-1:0] voice_note_q, voice_note_d;
  logic [DUR_WIDTH-1:0]  voice_dur_q, voice_dur_d;
  logic                  note_done_q, note_done_d;
  logic                  overflow_q, overflow_d;
  logic [IDX_W-1:0]      last_idx_q, last_idx_d;
  logic                  last_valid_q, last_valid_d;

  assign tick     = play & beat;
  assign any_load = |load_vec;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot #(
      .AGE_WIDTH(AGE_WIDTH)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .flush_i  (flush),
      .load_i   (load_vec[g]),
      .dur_i    (duration),
      .age_inc_i(any_load),
      .tick_i   (tick),
      .busy_o   (busy_w[g]),
      .age_o    (age_w[g]),
      .expire_o (expire_w[g])
    );
  end

  // Free-voice priority encoder and oldest-voice comparator, both on registered state.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!busy_w[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    old_idx = '0;
    old_age = age_w[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_w[i] > old_age) begin
        old_age = age_w[i];
        old_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    rest_note = new_note && !flush && (duration == REST_DURATION);
    accept    = new_note && !flush && (duration != REST_DURATION);
    sel_idx   = free_found ? free_idx : old_idx;
    load_vec  = '0;
    drop      = 1'b0;
    ovf_set   = 1'b0;
    if (accept) begin
      ovf_set = !free_found;
`ifdef VOICE_STEAL_EN
      load_vec[sel_idx] = 1'b1;
`else
      if (free_found) begin
        load_vec[sel_idx] = 1'b1;
      end else begin
        drop = 1'b1;
      end
`endif
    end
  end

  // A new load replaces last_idx, so the old last voice expiring alongside it is silent.
  assign last_expire = last_valid_q && expire_w[last_idx_q] && !any_load && !flush;

  always_comb begin
    load_voice_d = load_vec;
    voice_done_d = flush ? '0 : (expire_w & ~load_vec);
    note_done_d  = rest_note | drop | last_expire;
    overflow_d   = flush ? 1'b0 : (overflow_q | ovf_set);
    last_idx_d   = any_load ? sel_idx : last_idx_q;
    voice_note_d = any_load ? note : voice_note_q;
    voice_dur_d  = any_load ? duration : voice_dur_q;
    last_valid_d = last_valid_q;
    if (flush) begin
      last_valid_d = 1'b0;
    end else if (any_load) begin
      last_valid_d = 1'b1;
    end else if (last_expire) begin
      last_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_voice_q <= '0;
      voice_done_q <= '0;
      voice_note_q <= '0;
      voice_dur_q  <= '0;
      note_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      last_idx_q   <= '0;
      last_valid_q <= 1'b0;
    end else begin
      load_voice_q <= load_voice_d;
      voice_done_q <= voice_done_d;
      voice_note_q <= voice_note_d;
      voice_dur_q  <= voice_dur_d;
      note_done_q  <= note_done_d;
      overflow_q   <= overflow_d;
      last_idx_q   <= last_idx_d;
      last_valid_q <= last_valid_d;
    end
  end

  assign load_voice     = load_voice_q;
  assign voice_done     = voice_done_q;
  assign voice_note     = voice_note_q;
  assign voice_duration = voice_dur_q;
  assign voice_busy     = busy_w;
  assign note_done      = note_done_q;
  assign overflow       = overflow_q;

endmodule
